// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
// Types and constants shared by the FIFO-drain UART transmitter.
//   state_e     : transmitter FSM state encoding
//   MARK, SPACE : serial line levels (idle line sits at MARK)
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_START = 3'd3,
      ST_DATA  = 3'd4,
      ST_STOP  = 3'd5
   } state_e;

   localparam logic MARK  = 1'b1;
   localparam logic SPACE = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_if
// FIFO read port as seen by its single consumer.
//   dout  : FIFO read data, valid the cycle after an rd_en pulse
//   empty : FIFO empty flag
//   rd_en : one-cycle pop request
// Modports: master = consumer (transmitter), slave = FIFO.
// ---------------------------------------------------------------------------
interface fifo_uart_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] dout;
   logic              empty;
   logic              rd_en;

   modport master (output rd_en, input dout, input empty);
   modport slave  (input rd_en, output dout, output empty);
endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Bit-period down-counter. load_i forces the counter to CLKS_PER_BIT-1; at
// terminal count it reloads by itself so consecutive bits need no extra load.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (counter cleared to 0)
//   load_i     : restart the bit period
//   tick_o     : counter at 0 (last cycle of the current bit)
//   pre_tick_o : counter at 1 (next cycle is the last of the bit)
// ---------------------------------------------------------------------------
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   output logic tick_o,
   output logic pre_tick_o
);
   localparam int            CW     = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // next count: explicit load, auto-reload at terminal count, else decrement
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = RELOAD;
      end else if (cnt_q == '0) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o     = (cnt_q == '0);
   assign pre_tick_o = (cnt_q == CW'(1));
endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Drains the upstream FIFO one byte at a time and sends each byte as an
// 8N1/8N2 UART frame, LSB first.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   tx_en_i    : allow starting new frames
//   fifo_if    : FIFO read port (master side: drives rd_en)
//   txd_o      : serial line, idle = MARK
//   busy_o     : high from FETCH through the last stop-bit cycle
//   done_o     : one-cycle pulse on the last stop-bit cycle
//   tx_count_o : frames completed since reset, wraps
// All outputs are registered from next-state values so they line up with the
// state they describe (e.g. txd_o is SPACE exactly while in START).
// ---------------------------------------------------------------------------
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8,
   parameter int STOP_BITS    = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tx_en_i,
   fifo_uart_tx_if.master   fifo_if,
   output logic             txd_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] tx_count_o
);
   // bit index is shared between data bits and stop bits
   localparam int               IDX_W     = (DATA_W > 2) ? $clog2(DATA_W) : 2;
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                txd_q, txd_d;
   logic                rd_en_q, rd_en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                timer_load_s, tick_s, pre_tick_s;

   // hold the timer at full period until the frame actually starts
   assign timer_load_s = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (timer_load_s),
      .tick_o     (tick_s),
      .pre_tick_o (pre_tick_s)
   );

   // FSM next state, datapath next values and next registered outputs
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (tx_en_i && !fifo_if.empty) state_d = ST_FETCH;
            else                           state_d = ST_IDLE;
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            shreg_d = fifo_if.dout;
            state_d = ST_START;
         end
         ST_START: begin
            if (tick_s) begin
               state_d = ST_DATA;
               idx_d   = '0;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
               if (idx_q == LAST_DATA) begin
                  state_d = ST_STOP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_STOP: begin
            if (tick_s) begin
               if (idx_q == LAST_STOP) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  count_d = count_q + CNT_W'(1);
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      rd_en_d = (state_d == ST_FETCH);
      busy_d  = (state_d != ST_IDLE);
      // the cycle after pre_tick in the last stop bit is the final frame cycle
      done_d  = (state_q == ST_STOP) && pre_tick_s && (idx_q == LAST_STOP);
      case (state_d)
         ST_START: txd_d = SPACE;
         ST_DATA:  txd_d = shreg_d[0];
         default:  txd_d = MARK;
      endcase
   end

   // state, datapath and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         count_q <= '0;
         txd_q   <= MARK;
         rd_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         txd_q   <= txd_d;
         rd_en_q <= rd_en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign fifo_if.rd_en = rd_en_q;
   assign txd_o         = txd_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign tx_count_o    = count_q;
endmodule
